// File: rtl/alu_operand_issue_pkg.sv
// Shared definitions for the ALU operand issue stage: opcode encodings and
// the issue FSM state type.
package alu_operand_issue_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SUM  = 3'd0;
  localparam logic [OP_W-1:0] OP_DIFF = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    COLLECT,
    EXEC,
    OUT
  } issueStateT;

endpackage

// File: rtl/alu_result_mux.sv
// Picks one of the arithmetic unit's result buses by opcode; opcodes with no
// matching bus yield zero and raise the illegal indication.
module alu_result_mux
  import alu_operand_issue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] sumIn,
  input  logic [DATA_W-1:0] diffIn,
  input  logic [DATA_W-1:0] andIn,
  input  logic [DATA_W-1:0] orIn,
  input  logic [DATA_W-1:0] xorIn,
  input  logic [DATA_W-1:0] xnorIn,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_SUM:  result = sumIn;
      OP_DIFF: result = diffIn;
      OP_AND:  result = andIn;
      OP_OR:   result = orIn;
      OP_XOR:  result = xorIn;
      OP_XNOR: result = xnorIn;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_operand_issue.sv
// Issue stage for the combinational ALU: pairs one A and one B operand, lets
// the unit settle for a cycle, then offers the selected result downstream.
module alu_operand_issue
  import alu_operand_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_a_valid,
  output logic              s_a_ready,
  input  logic [DATA_W-1:0] s_a_data,
  input  logic              s_b_valid,
  output logic              s_b_ready,
  input  logic [DATA_W-1:0] s_b_data,
  input  logic [OP_W-1:0]   s_b_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic [DATA_W-1:0] alu_diff,
  input  logic [DATA_W-1:0] alu_and,
  input  logic [DATA_W-1:0] alu_or,
  input  logic [DATA_W-1:0] alu_xor,
  input  logic [DATA_W-1:0] alu_xnor,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [OP_W-1:0]   m_op,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  pair_count
);

  issueStateT            state;
  issueStateT            nextState;
  logic                  aFull;
  logic                  bFull;
  logic                  aFire;
  logic                  bFire;
  logic                  outFire;
  logic [OP_W-1:0]       opReg;
  logic [DATA_W-1:0]     selResult;
  logic                  selIllegal;

  alu_result_mux #(
    .DATA_W (DATA_W)
  ) resultMux (
    .op      (opReg),
    .sumIn   (alu_sum),
    .diffIn  (alu_diff),
    .andIn   (alu_and),
    .orIn    (alu_or),
    .xorIn   (alu_xor),
    .xnorIn  (alu_xnor),
    .result  (selResult),
    .illegal (selIllegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= nextState;
  end

  // Operands are only accepted while collecting; each side holds off until
  // its partner arrives, so the pair may complete in either order.
  always_comb begin
    nextState = state;
    s_a_ready = 1'b0;
    s_b_ready = 1'b0;
    m_valid   = 1'b0;
    aFire     = 1'b0;
    bFire     = 1'b0;
    outFire   = 1'b0;
    case (state)
      COLLECT: begin
        s_a_ready = !aFull;
        s_b_ready = !bFull;
        aFire     = s_a_valid && !aFull;
        bFire     = s_b_valid && !bFull;
        if ((aFull || aFire) && (bFull || bFire)) nextState = EXEC;
      end
      EXEC: nextState = OUT;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          outFire   = 1'b1;
          nextState = COLLECT;
        end
      end
      default: nextState = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aFull <= 1'b0;
      bFull <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      opReg <= OP_SUM;
    end else begin
      if (aFire) begin
        alu_a <= s_a_data;
        aFull <= 1'b1;
      end
      if (bFire) begin
        alu_b <= s_b_data;
        opReg <= s_b_op;
        bFull <= 1'b1;
      end
      if (state == EXEC) begin
        aFull <= 1'b0;
        bFull <= 1'b0;
      end
    end
  end

  // The unit has had a full cycle on stable operands by the time EXEC ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      m_op       <= OP_SUM;
      illegal_op <= 1'b0;
    end else if (state == EXEC) begin
      m_data <= selResult;
      m_op   <= opReg;
      if (selIllegal) illegal_op <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pair_count <= '0;
    else if (outFire) pair_count <= pair_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: models the arithmetic unit, runs directed
// scenarios, then random traffic checked against a queue-based pairing model.
module tb_alu_operand_issue;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk;
  logic              rst_n;
  logic              s_a_valid;
  logic              s_a_ready;
  logic [DATA_W-1:0] s_a_data;
  logic              s_b_valid;
  logic              s_b_ready;
  logic [DATA_W-1:0] s_b_data;
  logic [2:0]        s_b_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_sum;
  logic [DATA_W-1:0] alu_diff;
  logic [DATA_W-1:0] alu_and;
  logic [DATA_W-1:0] alu_or;
  logic [DATA_W-1:0] alu_xor;
  logic [DATA_W-1:0] alu_xnor;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_op;
  logic              illegal_op;
  logic [CNT_W-1:0]  pair_count;

  int compared;
  int mismatched;

  // Reference model state
  logic [31:0] aQ[$];
  logic [31:0] bQ[$];
  logic [2:0]  opQ[$];
  logic [31:0] lastA;
  logic [31:0] lastB;
  logic        sawIllegal;
  logic        formed;
  logic        expValid;
  logic        expIllegal;
  int          pairAge;
  int          expCount;

  alu_operand_issue #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_a_valid  (s_a_valid),
    .s_a_ready  (s_a_ready),
    .s_a_data   (s_a_data),
    .s_b_valid  (s_b_valid),
    .s_b_ready  (s_b_ready),
    .s_b_data   (s_b_data),
    .s_b_op     (s_b_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sum    (alu_sum),
    .alu_diff   (alu_diff),
    .alu_and    (alu_and),
    .alu_or     (alu_or),
    .alu_xor    (alu_xor),
    .alu_xnor   (alu_xnor),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_op       (m_op),
    .illegal_op (illegal_op),
    .pair_count (pair_count)
  );

  // Combinational arithmetic unit
  assign alu_sum  = alu_a + alu_b;
  assign alu_diff = alu_a - alu_b;
  assign alu_and  = alu_a & alu_b;
  assign alu_or   = alu_a | alu_b;
  assign alu_xor  = alu_a ^ alu_b;
  assign alu_xnor = ~(alu_a ^ alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one A/B pair, B delayed by bLag cycles, and waits until both are taken
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input int bLag);
    bit aLeft = 1'b1;
    bit bLeft = 1'b1;
    int bWait = bLag;
    int guard = 0;
    while ((aLeft || bLeft) && guard < 100) begin
      s_a_valid = aLeft;
      s_a_data  = a;
      s_b_valid = bLeft && (bWait == 0);
      s_b_data  = b;
      s_b_op    = op;
      @(negedge clk);
      if (s_a_valid && s_a_ready) aLeft = 1'b0;
      if (s_b_valid && s_b_ready) bLeft = 1'b0;
      if (bWait > 0) bWait--;
      @(posedge clk);
      #1;
      guard++;
    end
    s_a_valid = 1'b0;
    s_b_valid = 1'b0;
    checkOutput("stim_accept", 32'(aLeft || bLeft), 32'd0);
  endtask

  // Waits for the output handshake and compares the delivered result
  task automatic checkResult(input string tag, input logic [31:0] expData,
                             input logic [2:0] expOp, output int lat);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (m_valid && m_ready) break;
      n++;
    end
    lat = n;
    checkOutput({tag, "_seen"}, 32'(n < 60), 32'd1);
    if (n < 60) begin
      checkOutput({tag, "_data"}, m_data, expData);
      checkOutput({tag, "_op"}, 32'(m_op), 32'(expOp));
    end
    @(posedge clk);
    #1;
  endtask

  // Pairing model: queues hold accepted operands until their result is taken
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aQ.delete();
        bQ.delete();
        opQ.delete();
        lastA      = '0;
        lastB      = '0;
        sawIllegal = 1'b0;
        pairAge    = 0;
        expCount   = 0;
      end else begin
        formed = (aQ.size() > 0) && (bQ.size() > 0);
        if (formed) pairAge++;
        expValid   = formed && (pairAge >= 2);
        expIllegal = sawIllegal || (expValid && (opQ[0] >= 3'd6));
        checkOutput("a_ready", 32'(s_a_ready), 32'(aQ.size() == 0));
        checkOutput("b_ready", 32'(s_b_ready), 32'(bQ.size() == 0));
        checkOutput("m_valid", 32'(m_valid), 32'(expValid));
        checkOutput("pair_count", 32'(pair_count), 32'(expCount % CNT_MOD));
        checkOutput("alu_a", alu_a, lastA);
        checkOutput("alu_b", alu_b, lastB);
        checkOutput("illegal_op", 32'(illegal_op), 32'(expIllegal));
        if (expValid) begin
          checkOutput("m_data", m_data, refResult(aQ[0], bQ[0], opQ[0]));
          checkOutput("m_op", 32'(m_op), 32'(opQ[0]));
          if (m_ready) begin
            sawIllegal = expIllegal;
            void'(aQ.pop_front());
            void'(bQ.pop_front());
            void'(opQ.pop_front());
            expCount++;
          end
        end
        if (s_a_valid && s_a_ready) begin
          aQ.push_back(s_a_data);
          lastA = s_a_data;
        end
        if (s_b_valid && s_b_ready) begin
          bQ.push_back(s_b_data);
          opQ.push_back(s_b_op);
          lastB = s_b_data;
        end
        if (!formed && (aQ.size() > 0) && (bQ.size() > 0)) pairAge = 0;
      end
    end
  end

  initial begin
    logic [31:0] logicExp[4];
    int lat;
    bit aGo;
    bit bGo;

    compared   = 0;
    mismatched = 0;
    logicExp   = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F};
    rst_n      = 1'b0;
    s_a_valid  = 1'b0;
    s_a_data   = '0;
    s_b_valid  = 1'b0;
    s_b_data   = '0;
    s_b_op     = 3'd0;
    m_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_m_op", 32'(m_op), 32'd0);
    checkOutput("rst_illegal", 32'(illegal_op), 32'd0);
    checkOutput("rst_count", 32'(pair_count), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] simultaneous sum pair");
    m_ready = 1'b1;
    applyStimulus(32'd5, 32'd3, 3'd0, 0);
    checkResult("t1_sum", 32'd8, 3'd0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd1);
    checkOutput("t1_count", 32'(pair_count), 32'd1);

    $display("[TB] late B difference");
    applyStimulus(32'd3, 32'd5, 3'd1, 4);
    checkResult("t2_diff", 32'hFFFFFFFE, 3'd1, lat);
    checkOutput("t2_illegal", 32'(illegal_op), 32'd0);

    $display("[TB] logic ops");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'hF0F0F0F0, 32'hFF00FF00, 3'(k + 2), 0);
      checkResult("t3_logic", logicExp[k], 3'(k + 2), lat);
    end

    $display("[TB] illegal op under backpressure");
    m_ready = 1'b0;
    applyStimulus(32'h12345678, 32'h1, 3'd7, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", 32'(m_valid), 32'd1);
      checkOutput("t4_hold_data", m_data, 32'd0);
    end
    checkOutput("t4_illegal_set", 32'(illegal_op), 32'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    checkResult("t4_illegal", 32'd0, 3'd7, lat);
    applyStimulus(32'd2, 32'd2, 3'd0, 0);
    checkResult("t4_legal", 32'd4, 3'd0, lat);
    checkOutput("t4_sticky", 32'(illegal_op), 32'd1);

    $display("[TB] A held while pair in flight");
    m_ready   = 1'b0;
    s_a_valid = 1'b1;
    s_a_data  = 32'd10;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_a_data  = 32'd20;
    s_b_valid = 1'b1;
    s_b_data  = 32'd7;
    s_b_op    = 3'd0;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_b_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_a_blocked", 32'(s_a_ready), 32'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    checkResult("t5_first", 32'd17, 3'd0, lat);
    @(negedge clk);
    checkOutput("t5_a_accept", 32'(s_a_ready), 32'd1);
    @(posedge clk);
    #1;
    s_a_valid = 1'b0;
    s_b_valid = 1'b1;
    s_b_data  = 32'd1;
    s_b_op    = 3'd0;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_b_valid = 1'b0;
    checkResult("t5_second", 32'd21, 3'd0, lat);

    $display("[TB] async reset during output");
    m_ready = 1'b0;
    applyStimulus(32'd1, 32'd2, 3'd0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_pre_valid", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("t6_rst_count", 32'(pair_count), 32'd0);
    checkOutput("t6_rst_illegal", 32'(illegal_op), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_a_ready", 32'(s_a_ready), 32'd1);
    checkOutput("t6_b_ready", 32'(s_b_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      aGo = s_a_valid && s_a_ready;
      bGo = s_b_valid && s_b_ready;
      @(posedge clk);
      #1;
      if (!s_a_valid || aGo) begin
        s_a_valid = ($urandom_range(0, 2) != 0);
        s_a_data  = $urandom;
      end
      if (!s_b_valid || bGo) begin
        s_b_valid = ($urandom_range(0, 2) != 0);
        s_b_data  = $urandom;
        s_b_op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                : 3'($urandom_range(0, 5));
      end
      m_ready = ($urandom_range(0, 3) != 0);
    end
    s_a_valid = 1'b0;
    s_b_valid = 1'b0;
    m_ready   = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Upstream issue stage for the 32-bit arithmetic/logic unit: pairs one operand word from each of two independent input streams (A FIFO, B FIFO) and drives the unit's a/b inputs from registers.
- Captures the unit's six result buses, selects one by the opcode carried with B, and presents it on a valid/ready output stream.
- Sits between the two operand FIFOs and the result consumer; the arithmetic unit itself stays purely combinational.

Parameters:
- DATA_W, 32, width of operands and results.
- CNT_W, 16, width of completed-pair counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_a_valid  in  1  A operand valid.
- s_a_ready  out  1  A operand accepted when valid&ready.
- s_a_data  in  DATA_W  A operand.
- s_b_valid  in  1  B operand valid.
- s_b_ready  out  1  B operand accepted when valid&ready.
- s_b_data  in  DATA_W  B operand.
- s_b_op  in  3  opcode sampled with B: 0 sum, 1 difference, 2 and, 3 or, 4 xor, 5 xnor, 6-7 illegal.
- alu_a  out  DATA_W  registered operand to unit input a.
- alu_b  out  DATA_W  registered operand to unit input b.
- alu_sum, alu_diff, alu_and, alu_or, alu_xor, alu_xnor  in  DATA_W each  unit result buses.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer ready.
- m_data  out  DATA_W  selected result.
- m_op  out  3  opcode that produced m_data.
- illegal_op  out  1  sticky flag, illegal opcode seen.
- pair_count  out  CNT_W  completed output handshakes.

Behaviour:
- Reset (async, rst_n=0): state COLLECT, a_full=b_full=0, alu_a=alu_b=0, m_valid=0, m_data=0, m_op=0, illegal_op=0, pair_count=0. Reset mid-operation drops any held operands/result silently.
- FSM states COLLECT, EXEC, OUT.
- COLLECT: s_a_ready=!a_full, s_b_ready=!b_full; A and B accepted independently, either order, both may fire same cycle. A fire loads alu_a, sets a_full; B fire loads alu_b and op register, sets b_full. When (a_full|a_fire)&(b_full|b_fire) -> EXEC next cycle.
- EXEC (one cycle): readies 0; m_data <= result selected by op; m_op <= op; ops 6/7 give m_data=0 and set illegal_op; clear a_full/b_full; -> OUT.
- OUT: m_valid=1, m_data/m_op stable until m_ready; readies 0. On m_valid&m_ready: pair_count+1 (wraps all-ones -> 0), m_valid=0 next cycle, -> COLLECT.
- Latency: last operand accepted on edge N -> EXEC during cycle N+1 -> m_valid high from cycle N+2. Minimum issue interval 3 cycles per pair.
- alu_a/alu_b hold last accepted values outside of loads; never change during EXEC.
- A word arriving while a_full stays pending (ready low); no overwrite, no loss.
- illegal_op cleared only by reset.
- Arithmetic done by unit; sum/difference wrap modulo 2^DATA_W, no carry/borrow reported.

Decomposition:
- Shared package: opcode constants OP_SUM..OP_XNOR, OP_W=3, FSM state enum (COLLECT/EXEC/OUT).
- Optional sub-module alu_result_mux (opcode -> result select, illegal detect); everything else in one module.

Test Plan:
- A=5 and B=3 op=0 same cycle, m_ready=1 -> m_valid on 2nd cycle after acceptance, m_data=8, m_op=0, pair_count=1.
- A=3 cycle 0, B=5 op=1 cycle 4 -> s_a_ready low cycles 1-4, m_data=0xFFFFFFFE, illegal_op=0.
- A=0xF0F0F0F0, B=0xFF00FF00 across ops 2,3,4,5 -> m_data 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0xF00FF00F in order.
- op=7, m_ready held low 10 cycles -> m_data=0, m_valid and m_data stable 10 cycles, illegal_op=1 and stays 1 after next legal pair.
- Second A valid while first held -> not accepted until after output handshake; values arrive in order.
- rst_n low during OUT -> m_valid=0, pair_count=0, illegal_op=0 immediately (async), readies high after release.
